id_hazard_ctrl: RTL and testbench

// - ID-side partner of the fetch stage: owns the IF/ID register and resolves branch/jump in ID.
// - Detects load-use and branch-operand hazards.
// - Drives the fetch control inputs Branch, Jump, JumpAddr and IFWrite back to fetch.
// - Emits a bubble request (Stall_id) to the ID/EX register.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/hazard_detect.sv | 33 +++
 rtl/id_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_id_hazard_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, the flush/reset NOP word and the ID control state encoding.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard check for the instruction in ID against the EX and MEM stages.
module hazard_detect (
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  input  logic [5:0] i_op,
  input  logic       i_reg_write_ex,
  input  logic       i_mem_read_ex,
  input  logic [4:0] i_reg_write_addr_ex,
  input  logic       i_mem_read_mem,
  input  logic [4:0] i_reg_write_addr_mem,
  output logic       o_hazard
);
  import cpu_pkg::*;

  logic w_is_br;
  logic w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt;
  logic w_load_use, w_br_alu, w_br_load;

  assign w_is_br = is_branch(i_op);

  // $0 is hardwired, so a write to it can never create a dependency.
  assign w_ex_rs  = (i_reg_write_addr_ex != 5'd0) && (i_reg_write_addr_ex == i_rs);
  assign w_ex_rt  = (i_reg_write_addr_ex != 5'd0) && (i_reg_write_addr_ex == i_rt);
  assign w_mem_rs = (i_reg_write_addr_mem != 5'd0) && (i_reg_write_addr_mem == i_rs);
  assign w_mem_rt = (i_reg_write_addr_mem != 5'd0) && (i_reg_write_addr_mem == i_rt);

  assign w_load_use = i_mem_read_ex && (w_ex_rs || (w_ex_rt && reads_rt(i_op)));
  assign w_br_alu   = w_is_br && i_reg_write_ex && !i_mem_read_ex && (w_ex_rs || w_ex_rt);
  assign w_br_load  = w_is_br && i_mem_read_mem && (w_mem_rs || w_mem_rt);

  assign o_hazard = w_load_use || w_br_alu || w_br_load;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID stage control: IF/ID register, branch/jump resolution in ID, hazard stalls and
// the fetch redirect/hold signals.
module id_hazard_ctrl #(
  parameter logic [31:0] NOP_INSTR   = cpu_pkg::NOP_INSTR,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            Instruction_if,
  input  logic [31:0]            PC_if,
  input  logic [31:0]            RsData_id,
  input  logic [31:0]            RtData_id,
  input  logic                   RegWrite_ex,
  input  logic                   MemRead_ex,
  input  logic [4:0]             RegWriteAddr_ex,
  input  logic                   MemRead_mem,
  input  logic [4:0]             RegWriteAddr_mem,
  output logic [31:0]            Instruction_id,
  output logic [31:0]            PC_id,
  output logic                   Branch,
  output logic                   Jump,
  output logic [31:0]            JumpAddr,
  output logic                   IFWrite,
  output logic                   Stall_id,
  output logic [STALL_CNT_W-1:0] StallCount
);
  import cpu_pkg::*;

  state_e r_state, w_state_next;

  logic [31:0]            r_instr, r_pc;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic [5:0]  w_op;
  logic        w_hazard, w_is_beq, w_is_bne, w_is_jmp, w_taken;
  logic [31:0] w_pc4, w_br_target, w_j_target;

  assign w_op     = r_instr[31:26];
  assign w_is_beq = (w_op == OP_BEQ);
  assign w_is_bne = (w_op == OP_BNE);
  assign w_is_jmp = (w_op == OP_J) || (w_op == OP_JAL);
  assign w_taken  = (w_is_beq && (RsData_id == RtData_id)) ||
                    (w_is_bne && (RsData_id != RtData_id)) || w_is_jmp;

  assign w_pc4       = r_pc + 32'd4;
  assign w_br_target = w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_j_target  = {w_pc4[31:28], r_instr[25:0], 2'b00};

  hazard_detect u_hazard_detect (
    .i_rs                 (r_instr[25:21]),
    .i_rt                 (r_instr[20:16]),
    .i_op                 (w_op),
    .i_reg_write_ex       (RegWrite_ex),
    .i_mem_read_ex        (MemRead_ex),
    .i_reg_write_addr_ex  (RegWriteAddr_ex),
    .i_mem_read_mem       (MemRead_mem),
    .i_reg_write_addr_mem (RegWriteAddr_mem),
    .o_hazard             (w_hazard)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = RUN;
    unique case (r_state)
      RUN, STALL: begin
        if (w_hazard)     w_state_next = STALL;
        else if (w_taken) w_state_next = FLUSH;
        else              w_state_next = RUN;
      end
      FLUSH:   w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  // STALL re-evaluates like RUN; only FLUSH suppresses decode of the NOP in ID.
  always_comb begin
    Branch   = 1'b0;
    Jump     = 1'b0;
    JumpAddr = 32'd0;
    IFWrite  = 1'b1;
    Stall_id = 1'b0;
    unique case (r_state)
      RUN, STALL: begin
        if (w_hazard) begin
          IFWrite  = 1'b0;
          Stall_id = 1'b1;
        end else if (w_taken) begin
          Branch   = w_is_beq || w_is_bne;
          Jump     = w_is_jmp;
          JumpAddr = w_is_jmp ? w_j_target : w_br_target;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'd0;
    end else if (Stall_id) begin
      r_instr <= r_instr;
      r_pc    <= r_pc;
    end else if (Branch || Jump) begin
      r_instr <= NOP_INSTR;
      r_pc    <= PC_if;
    end else begin
      r_instr <= Instruction_if;
      r_pc    <= PC_if;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (Stall_id && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign Instruction_id = r_instr;
  assign PC_id          = r_pc;
  assign StallCount     = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl; expectations go through a scoreboard queue.
module tb_id_hazard_ctrl;

  localparam int unsigned CW = 3;

  typedef struct {
    string       tag;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br;
    logic        jmp;
    logic [31:0] jaddr;
    logic        ifw;
    logic        stl;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   Instruction_if, PC_if, RsData_id, RtData_id;
  logic          RegWrite_ex, MemRead_ex, MemRead_mem;
  logic [4:0]    RegWriteAddr_ex, RegWriteAddr_mem;
  logic [31:0]   Instruction_id, PC_id, JumpAddr;
  logic          Branch, Jump, IFWrite, Stall_id;
  logic [CW-1:0] StallCount;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  id_hazard_ctrl #(
    .NOP_INSTR   (32'h0000_0000),
    .STALL_CNT_W (CW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Instruction_if   (Instruction_if),
    .PC_if            (PC_if),
    .RsData_id        (RsData_id),
    .RtData_id        (RtData_id),
    .RegWrite_ex      (RegWrite_ex),
    .MemRead_ex       (MemRead_ex),
    .RegWriteAddr_ex  (RegWriteAddr_ex),
    .MemRead_mem      (MemRead_mem),
    .RegWriteAddr_mem (RegWriteAddr_mem),
    .Instruction_id   (Instruction_id),
    .PC_id            (PC_id),
    .Branch           (Branch),
    .Jump             (Jump),
    .JumpAddr         (JumpAddr),
    .IFWrite          (IFWrite),
    .Stall_id         (Stall_id),
    .StallCount       (StallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cmp(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expectation, wait for the DUT outputs to settle, then pop and compare.
  task automatic chk(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                     input logic br, input logic jmp, input logic [31:0] jaddr,
                     input logic ifw, input logic stl, input logic [CW-1:0] cnt,
                     input bit now);
    exp_t e;
    e.tag = tag; e.instr = instr; e.pc = pc; e.br = br; e.jmp = jmp;
    e.jaddr = jaddr; e.ifw = ifw; e.stl = stl; e.cnt = cnt;
    sb.push_back(e);
    if (now) #1;
    else     @(negedge clk);
    e = sb.pop_front();
    cmp(e.tag, "Instruction_id", Instruction_id, e.instr);
    cmp(e.tag, "PC_id", PC_id, e.pc);
    cmp(e.tag, "Branch", {31'd0, Branch}, {31'd0, e.br});
    cmp(e.tag, "Jump", {31'd0, Jump}, {31'd0, e.jmp});
    cmp(e.tag, "JumpAddr", JumpAddr, e.jaddr);
    cmp(e.tag, "IFWrite", {31'd0, IFWrite}, {31'd0, e.ifw});
    cmp(e.tag, "Stall_id", {31'd0, Stall_id}, {31'd0, e.stl});
    cmp(e.tag, "StallCount", {{(32-CW){1'b0}}, StallCount}, {{(32-CW){1'b0}}, e.cnt});
  endtask

  initial begin
    reset = 1'b0;
    Instruction_if = 32'd0; PC_if = 32'd0; RsData_id = 32'd0; RtData_id = 32'd0;
    RegWrite_ex = 1'b0; MemRead_ex = 1'b0; RegWriteAddr_ex = 5'd0;
    MemRead_mem = 1'b0; RegWriteAddr_mem = 5'd0;

    repeat (3) step();
    chk("reset", 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0);
    reset = 1'b1;
    step();

    // Load-use: add $3,$2,$4 behind lw $2.
    Instruction_if = 32'h0044_1820; PC_if = 32'h40;
    chk("idle", 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0);
    step();
    MemRead_ex = 1'b1; RegWriteAddr_ex = 5'd2;
    Instruction_if = 32'h1021_0003; PC_if = 32'h10;
    chk("lu_stall", 32'h0044_1820, 32'h40, 0, 0, 32'h0, 0, 1, 0, 0);
    step();
    MemRead_ex = 1'b0; RegWriteAddr_ex = 5'd0;
    chk("lu_release", 32'h0044_1820, 32'h40, 0, 0, 32'h0, 1, 0, 1, 0);
    step();

    // beq $1,$1,+3 at 0x10, taken.
    RsData_id = 32'd5; RtData_id = 32'd5;
    Instruction_if = 32'h3000_0000; PC_if = 32'h20;
    chk("beq_taken", 32'h1021_0003, 32'h10, 1, 0, 32'h20, 1, 0, 1, 0);
    step();
    Instruction_if = 32'h1421_0003; PC_if = 32'h10;
    chk("beq_flush", 32'h0, 32'h20, 0, 0, 32'h0, 1, 0, 1, 0);
    step();

    // bne with equal operands: falls through.
    Instruction_if = 32'h0800_0040; PC_if = 32'h100;
    chk("bne_nt", 32'h1421_0003, 32'h10, 0, 0, 32'h0, 1, 0, 1, 0);
    step();

    // j at 0x100.
    Instruction_if = 32'h10A0_0001; PC_if = 32'h200;
    chk("j_taken", 32'h0800_0040, 32'h100, 0, 1, 32'h100, 1, 0, 1, 0);
    step();
    chk("j_flush", 32'h0, 32'h200, 0, 0, 32'h0, 1, 0, 1, 0);
    step();

    // beq $5,$0,+1 behind lw $5: stall with lw in EX, again with lw in MEM.
    RegWrite_ex = 1'b1; MemRead_ex = 1'b1; RegWriteAddr_ex = 5'd5;
    RsData_id = 32'd7; RtData_id = 32'd0;
    Instruction_if = 32'h3333_0000; PC_if = 32'h204;
    chk("bl_stall1", 32'h10A0_0001, 32'h200, 0, 0, 32'h0, 0, 1, 1, 0);
    step();
    RegWrite_ex = 1'b0; MemRead_ex = 1'b0; RegWriteAddr_ex = 5'd0;
    MemRead_mem = 1'b1; RegWriteAddr_mem = 5'd5;
    chk("bl_stall2", 32'h10A0_0001, 32'h200, 0, 0, 32'h0, 0, 1, 2, 0);
    step();
    MemRead_mem = 1'b0; RegWriteAddr_mem = 5'd0;
    RsData_id = 32'd0;
    chk("bl_resolve", 32'h10A0_0001, 32'h200, 1, 0, 32'h208, 1, 0, 3, 0);
    step();
    Instruction_if = 32'h10A0_0001; PC_if = 32'h300;
    chk("bl_flush", 32'h0, 32'h204, 0, 0, 32'h0, 1, 0, 3, 0);
    step();

    // Same branch hazard, aborted by reset during the first stall cycle.
    RegWrite_ex = 1'b1; MemRead_ex = 1'b1; RegWriteAddr_ex = 5'd5;
    chk("rv_stall1", 32'h10A0_0001, 32'h300, 0, 0, 32'h0, 0, 1, 3, 0);
    reset = 1'b0;
    chk("rv_reset", 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 1);
    RegWrite_ex = 1'b0; MemRead_ex = 1'b0; RegWriteAddr_ex = 5'd0;
    step();
    chk("rv_hold", 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 0);
    reset = 1'b1;
    Instruction_if = 32'h0044_1820; PC_if = 32'h400;
    chk("rv_after", 32'h0, 32'h0, 0, 0, 32'h0, 1, 0, 0, 1);
    step();
    chk("rv_load", 32'h0044_1820, 32'h400, 0, 0, 32'h0, 1, 0, 0, 0);

    // Long load-use on rt: counter saturates and does not wrap.
    MemRead_ex = 1'b1; RegWriteAddr_ex = 5'd4;
    repeat (9) step();
    chk("sat", 32'h0044_1820, 32'h400, 0, 0, 32'h0, 0, 1, 7, 0);
    step();
    chk("sat_hold", 32'h0044_1820, 32'h400, 0, 0, 32'h0, 0, 1, 7, 0);
    MemRead_ex = 1'b0; RegWriteAddr_ex = 5'd0;
    chk("sat_release", 32'h0044_1820, 32'h400, 0, 0, 32'h0, 1, 0, 7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
